// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter
// Shares one single-port synchronous RAM between the jedro_1 instruction-fetch
// port and the load/store data port. Data wins conflicts unless fetch has been
// denied STARVE_LIMIT consecutive cycles. Grants are combinational. Responses
// come back one cycle later, routed by a registered owner state, so a new
// access can issue every cycle.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   instr_req_i/addr_i              fetch request and address
//   instr_gnt_o/rvalid_o/rdata_o    fetch grant, response valid, response data
//   data_req_i/we_i/be_i/addr_i     load/store request, write flag, byte enables, address
//   data_wdata_i                    store data
//   data_gnt_o/rvalid_o/rdata_o     data grant, response valid/store ack, load data
//   mem_en_o/we_o/addr_o/wdata_o    RAM enable, per-byte write mask, address, write data
//   mem_rdata_i                     RAM read data, valid one cycle after mem_en_o
//
// Response owner states:
//   state      | meaning
//   RESP_NONE  | no access was granted last cycle; no rvalid
//   RESP_INSTR | last cycle granted fetch; mem_rdata_i goes to the fetch port
//   RESP_DATA  | last cycle granted data; mem_rdata_i goes to the data port

module jedro_1_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,

  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  // $clog2(1) is 0, so a zero limit still needs a 1-bit counter
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INSTR,
    RESP_DATA
  } resp_e;

  resp_e         r_owner;
  logic [SW-1:0] r_starve_cnt;

  logic w_instr_win;
  logic w_instr_gnt;
  logic w_data_gnt;

  // With STARVE_LIMIT = 0 the counter sits at 0 == LIMIT, so fetch always wins
  assign w_instr_win = instr_req_i && (!data_req_i || (r_starve_cnt == LIMIT));
  assign w_instr_gnt = !rst_i && w_instr_win;
  assign w_data_gnt  = !rst_i && data_req_i && !w_instr_win;

  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;

  assign mem_en_o    = w_instr_gnt || w_data_gnt;
  assign mem_addr_o  = w_instr_gnt ? instr_addr_i : data_addr_i;
  assign mem_we_o    = (w_data_gnt && data_we_i) ? data_be_i : {BE_W{1'b0}};
  assign mem_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner      <= RESP_NONE;
      r_starve_cnt <= '0;
    end else begin
      if (w_instr_gnt) begin
        r_owner <= RESP_INSTR;
      end else if (w_data_gnt) begin
        r_owner <= RESP_DATA;
      end else begin
        r_owner <= RESP_NONE;
      end

      if (!instr_req_i || w_instr_gnt) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
    end
  end

  // RAM data is only valid the cycle after an access, so route it by owner
  assign instr_rvalid_o = (r_owner == RESP_INSTR);
  assign data_rvalid_o  = (r_owner == RESP_DATA);
  assign instr_rdata_o  = (r_owner == RESP_INSTR) ? mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign data_rdata_o   = (r_owner == RESP_DATA)  ? mem_rdata_i : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Two-requester arbiter that shares one single-port synchronous RAM between the jedro_1 instruction-fetch port and the load/store data port. It sits between `jedro_1_top` and a single memory macro, so a unified instruction/data memory can run the core. Data accesses have priority. A starvation counter guarantees forward progress of fetch. Responses are pipelined: a new grant can issue every cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width, byte addresses.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles before fetch is forced to win; 0 means fetch always wins a conflict.

Ports (name, direction, width, meaning):
- Clock and reset:
  - `clk_i` in 1: the single clock.
  - `rst_i` in 1: reset, **synchronous, active-high**.
- Instruction port:
  - `instr_req_i` in 1: fetch request.
  - `instr_addr_i` in ADDR_WIDTH: fetch address.
  - `instr_gnt_o` out 1: fetch accepted this cycle.
  - `instr_rvalid_o` out 1: fetch data valid.
  - `instr_rdata_o` out DATA_WIDTH: fetch data.
- Data port:
  - `data_req_i` in 1: load/store request.
  - `data_we_i` in 1: 1 for a store.
  - `data_be_i` in DATA_WIDTH/8: byte enables.
  - `data_addr_i` in ADDR_WIDTH: data address.
  - `data_wdata_i` in DATA_WIDTH: store data.
  - `data_gnt_o` out 1: data request accepted.
  - `data_rvalid_o` out 1: load data valid, or store acknowledge.
  - `data_rdata_o` out DATA_WIDTH: load data.
- Memory port:
  - `mem_en_o` out 1: memory access enable.
  - `mem_we_o` out DATA_WIDTH/8: per-byte write mask.
  - `mem_addr_o` out ADDR_WIDTH: memory address.
  - `mem_wdata_o` out DATA_WIDTH: memory write data.
  - `mem_rdata_i` in DATA_WIDTH: memory read data, valid 1 cycle after `mem_en_o`.

## Operation
- **Grant logic (combinational, same cycle as request):**
  - Only `instr_req_i` high: grant instr.
  - Only `data_req_i` high: grant data.
  - Both high: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant instr.
  - At most one `*_gnt_o` is high per cycle. A grant is never issued while `rst_i` is high.
- **Memory drive follows the granted requester:**
  - `mem_en_o` = any grant.
  - `mem_addr_o` is the granted address.
  - `mem_we_o` = `data_be_i` when a data store is granted, else 0.
  - `mem_wdata_o` = `data_wdata_i`.
  - With no grant, `mem_en_o` = 0, `mem_we_o` = 0, and address/wdata are don't-care.
- **`starve_cnt` (width clog2(STARVE_LIMIT+1), minimum 1):**
  - Clears when `instr_req_i` is low or instr is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
- **Response owner register, states RESP_NONE / RESP_INSTR / RESP_DATA:**
  - Next state = the port granted this cycle, or RESP_NONE if no grant.
  - Any state can move to any state each cycle, so back-to-back grants pipeline.
- **Outputs by owner state:**
  - RESP_INSTR: `instr_rvalid_o` = 1, `instr_rdata_o` = `mem_rdata_i`.
  - RESP_DATA: `data_rvalid_o` = 1, `data_rdata_o` = `mem_rdata_i`. For a store, rdata is don't-care.
  - Non-owner rdata outputs are driven to 0.
- **Requester obligations:** hold request, address, wdata and be stable until granted. Requests are not retracted by the arbiter.

## Timing
- **Reset:** while `rst_i` is high at a rising edge:
  - Owner becomes RESP_NONE and `starve_cnt` = 0.
  - In the next cycle `instr_rvalid_o`, `data_rvalid_o` = 0, and both rdata outputs = 0.
  - All grant and `mem_*` enable outputs are 0 during reset.
- **Latency:** grant in cycle N gives rvalid in cycle N+1. Throughput is one access per cycle.
- **Reset mid-operation:** an access granted in the cycle before reset asserts still gets its rvalid. An access whose rvalid would fall in a reset cycle is discarded. Nothing is replayed after reset.
- **Simultaneous events:**
  - A grant in cycle N and an rvalid for the grant of N-1 coexist.
  - A data store granted in N is written at edge N+1. A fetch of the same address granted in N+1 returns the new data. Read-after-write ordering follows grant order.
- **Starvation bound:** a continuously requesting fetch is granted within STARVE_LIMIT+1 cycles.

## Test plan
- **Reset:** hold `rst_i` = 1 for 3 cycles with both requests high -> no grants, `mem_en_o` = 0, both rvalid = 0. First cycle after release: data is granted.
- **Single fetch:** `instr_req_i` = 1 to address 0x0000_0010, memory holds 0x0050_0293 -> `instr_gnt_o` = 1 in cycle N; in N+1 `instr_rvalid_o` = 1 and `instr_rdata_o` = 0x0050_0293, `data_rvalid_o` = 0.
- **Store then fetch:** data store 0xDEAD_BEEF with be = 4'b1111 to 0x20 in cycle N; fetch 0x20 in N+1 -> `mem_we_o` = 4'b1111 in N, `data_rvalid_o` in N+1, fetch returns 0xDEAD_BEEF in N+2.
- **Byte store:** be = 4'b0010, wdata 0x0000_AB00 to a word holding 0x1111_1111 -> a subsequent load returns 0x1111_AB11.
- **Starvation (STARVE_LIMIT = 4):** both requests held high continuously -> data granted cycles 0–3, instr granted cycle 4, then the counter clears and data is granted in cycle 5.
- **Reset mid-pipeline:** fetch granted in cycle N, `rst_i` = 1 in N+1 -> `instr_rvalid_o` = 1 in N+1. No rvalid in N+2, and the owner is RESP_NONE.
